// File: rtl/carregador_de_programa.sv
`default_nettype none
// ============================================================================
// Module   : carregador_de_programa
// Purpose  : UART (8N1) program loader. It frames the received bytes into
//            16-bit words and writes them through the instruction memory's
//            external load port. The processor is held in reset until a
//            frame with a matching checksum has been loaded.
// Revision : 1.0 - initial release
// ============================================================================
module carregador_de_programa #(
  parameter int          CLKS_POR_BIT     = 434,
  parameter logic [15:0] ENDERECO_INICIAL = 16'h0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        rx,
  output logic        mem_wr,
  output logic [15:0] mem_in,
  output logic [15:0] endereco_ext,
  output logic        segura_proc,
  output logic        carregando,
  output logic        erro,
  output logic [15:0] palavras
);

  // Bit-period counter width and the two compare points it needs.
  localparam int                CNT_W       = $clog2(CLKS_POR_BIT);
  localparam logic [CNT_W-1:0]  c_meio_bit  = CNT_W'(CLKS_POR_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  c_fim_bit   = CNT_W'(CLKS_POR_BIT - 1);
  localparam logic [7:0]        c_cabecalho = 8'hA5;

  typedef enum logic [1:0] {
    RX_OCIOSO = 2'd0,
    RX_INICIO = 2'd1,
    RX_DADOS  = 2'd2,
    RX_PARADA = 2'd3
  } rx_estado_t;

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    CONT_H = 3'd1,
    CONT_L = 3'd2,
    DADO_H = 3'd3,
    DADO_L = 3'd4,
    SOMA   = 3'd5
  } estado_t;

  // --------------------------------------------------------------------------
  // Input synchroniser and edge history
  // --------------------------------------------------------------------------
  logic rx_s1_q, rx_s2_q, rx_ant_q;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clock) begin
    if (resetn) begin
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      rx_ant_q <= 1'b1;
    end else begin
      rx_s1_q  <= rx;
      rx_s2_q  <= rx_s1_q;
      rx_ant_q <= rx_s2_q;
    end
  end

  // --------------------------------------------------------------------------
  // UART receiver
  // --------------------------------------------------------------------------
  rx_estado_t       rx_estado_q, rx_estado_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       desloc_q, desloc_d;
  logic             byte_ok_q, byte_ok_d;
  logic             byte_err_q, byte_err_d;

  // Receiver next state: start validation at mid-bit, then one sample per bit.
  always_comb begin
    rx_estado_d = rx_estado_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    desloc_d    = desloc_q;
    byte_ok_d   = 1'b0;
    byte_err_d  = 1'b0;
    case (rx_estado_q)
      RX_OCIOSO: begin
        if (!rx_s2_q && rx_ant_q) begin
          rx_estado_d = RX_INICIO;
          cnt_d       = '0;
        end
      end
      RX_INICIO: begin
        if (cnt_q == c_meio_bit) begin
          cnt_d = '0;
          bit_d = 3'd0;
          // A line already back high at mid-start is a glitch.
          rx_estado_d = rx_s2_q ? RX_OCIOSO : RX_DADOS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DADOS: begin
        if (cnt_q == c_fim_bit) begin
          cnt_d    = '0;
          desloc_d = {rx_s2_q, desloc_q[7:1]};
          bit_d    = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            rx_estado_d = RX_PARADA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_PARADA: begin
        if (cnt_q == c_fim_bit) begin
          cnt_d       = '0;
          byte_ok_d   = rx_s2_q;
          byte_err_d  = !rx_s2_q;
          // Back to idle half a bit early so a back-to-back start is seen.
          rx_estado_d = RX_OCIOSO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: rx_estado_d = RX_OCIOSO;
    endcase
  end

  // Receiver state register.
  always_ff @(posedge clock) begin
    if (resetn) begin
      rx_estado_q <= RX_OCIOSO;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      desloc_q    <= 8'h00;
      byte_ok_q   <= 1'b0;
      byte_err_q  <= 1'b0;
    end else begin
      rx_estado_q <= rx_estado_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      desloc_q    <= desloc_d;
      byte_ok_q   <= byte_ok_d;
      byte_err_q  <= byte_err_d;
    end
  end

  // The shift register holds the finished byte while byte_ok_q is high.
  logic [7:0] byte_rx;
  assign byte_rx = desloc_q;

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  estado_t     estado_q, estado_d;
  logic [15:0] n_q, n_d;
  logic [7:0]  alto_q, alto_d;
  logic [7:0]  acum_q, acum_d;
  logic [15:0] endereco_q, endereco_d;
  logic [15:0] palavras_q, palavras_d;
  logic        mem_wr_q, mem_wr_d;
  logic [15:0] mem_in_q, mem_in_d;
  logic        segura_q, segura_d;
  logic        carregando_q, carregando_d;
  logic        erro_q, erro_d;

  // Frame sequencing, checksum accumulation and write-strobe generation.
  always_comb begin
    estado_d     = estado_q;
    n_d          = n_q;
    alto_d       = alto_q;
    acum_d       = acum_q;
    endereco_d   = endereco_q;
    palavras_d   = palavras_q;
    mem_wr_d     = 1'b0;
    mem_in_d     = mem_in_q;
    segura_d     = segura_q;
    carregando_d = carregando_q;
    erro_d       = erro_q;
    case (estado_q)
      OCIOSO: begin
        if (byte_ok_q && byte_rx == c_cabecalho) begin
          estado_d     = CONT_H;
          carregando_d = 1'b1;
          segura_d     = 1'b1;
          erro_d       = 1'b0;
          acum_d       = 8'h00;
          palavras_d   = 16'h0000;
          endereco_d   = ENDERECO_INICIAL;
        end
      end
      CONT_H: begin
        if (byte_ok_q) begin
          n_d[15:8] = byte_rx;
          acum_d    = acum_q ^ byte_rx;
          estado_d  = CONT_L;
        end
      end
      CONT_L: begin
        if (byte_ok_q) begin
          n_d[7:0] = byte_rx;
          acum_d   = acum_q ^ byte_rx;
          estado_d = ({n_q[15:8], byte_rx} == 16'h0000) ? SOMA : DADO_H;
        end
      end
      DADO_H: begin
        if (byte_ok_q) begin
          alto_d   = byte_rx;
          acum_d   = acum_q ^ byte_rx;
          estado_d = DADO_L;
        end
      end
      DADO_L: begin
        if (mem_wr_q) begin
          // The address is held through the strobe and advanced afterwards.
          endereco_d = endereco_q + 16'd1;
          palavras_d = palavras_q + 16'd1;
          estado_d   = ((palavras_q + 16'd1) < n_q) ? DADO_H : SOMA;
        end else if (byte_ok_q) begin
          mem_wr_d = 1'b1;
          mem_in_d = {alto_q, byte_rx};
          acum_d   = acum_q ^ byte_rx;
        end
      end
      SOMA: begin
        if (byte_ok_q) begin
          carregando_d = 1'b0;
          estado_d     = OCIOSO;
          if (byte_rx == acum_q) begin
            segura_d = 1'b0;
            erro_d   = 1'b0;
          end else begin
            erro_d = 1'b1;
          end
        end
      end
      default: estado_d = OCIOSO;
    endcase

    // A bad stop bit inside a frame aborts it like a checksum failure.
    if (byte_err_q && estado_q != OCIOSO) begin
      estado_d     = OCIOSO;
      erro_d       = 1'b1;
      carregando_d = 1'b0;
      mem_wr_d     = 1'b0;
    end
  end

  // Frame FSM and output registers.
  always_ff @(posedge clock) begin
    if (resetn) begin
      estado_q     <= OCIOSO;
      n_q          <= 16'h0000;
      alto_q       <= 8'h00;
      acum_q       <= 8'h00;
      endereco_q   <= ENDERECO_INICIAL;
      palavras_q   <= 16'h0000;
      mem_wr_q     <= 1'b0;
      mem_in_q     <= 16'h0000;
      segura_q     <= 1'b0;
      carregando_q <= 1'b0;
      erro_q       <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      n_q          <= n_d;
      alto_q       <= alto_d;
      acum_q       <= acum_d;
      endereco_q   <= endereco_d;
      palavras_q   <= palavras_d;
      mem_wr_q     <= mem_wr_d;
      mem_in_q     <= mem_in_d;
      segura_q     <= segura_d;
      carregando_q <= carregando_d;
      erro_q       <= erro_d;
    end
  end

  assign mem_wr       = mem_wr_q;
  assign mem_in       = mem_in_q;
  assign endereco_ext = endereco_q;
  assign segura_proc  = segura_q;
  assign carregando   = carregando_q;
  assign erro         = erro_q;
  assign palavras     = palavras_q;

endmodule
`default_nettype wire

// File: tb/tb_carregador_de_programa.sv
`default_nettype none
// ============================================================================
// Module   : tb_carregador_de_programa
// Purpose  : Self-checking bench for carregador_de_programa. Two instances
//            (base address 0000 and FFFF) share one serial line; a frame-level
//            reference model predicts writes and status after every frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_carregador_de_programa;

  localparam int CPB = 4;

  logic clock = 1'b0;
  logic resetn = 1'b1;
  logic rx = 1'b1;

  logic        wr0, seg0, car0, err0;
  logic [15:0] in0, end0, pal0;
  logic        wr1, seg1, car1, err1;
  logic [15:0] in1, end1, pal1;

  always #5 clock = ~clock;

  carregador_de_programa #(.CLKS_POR_BIT(CPB), .ENDERECO_INICIAL(16'h0000)) dut0 (
    .clock(clock), .resetn(resetn), .rx(rx),
    .mem_wr(wr0), .mem_in(in0), .endereco_ext(end0),
    .segura_proc(seg0), .carregando(car0), .erro(err0), .palavras(pal0)
  );

  carregador_de_programa #(.CLKS_POR_BIT(CPB), .ENDERECO_INICIAL(16'hFFFF)) dut1 (
    .clock(clock), .resetn(resetn), .rx(rx),
    .mem_wr(wr1), .mem_in(in1), .endereco_ext(end1),
    .segura_proc(seg1), .carregando(car1), .erro(err1), .palavras(pal1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observed writes, {address, data}, captured on the falling edge.
  logic [31:0] obs_q0[$];
  logic [31:0] obs_q1[$];
  logic        pw0 = 1'b0;
  logic        pw1 = 1'b0;

  // Record every write strobe and check it is a single cycle inside a frame.
  always @(negedge clock) begin
    if (wr0) begin
      chk("wr0_width", {31'd0, pw0}, 32'd0);
      chk("wr0_in_frame", {31'd0, car0}, 32'd1);
      obs_q0.push_back({end0, in0});
    end
    if (wr1) begin
      chk("wr1_width", {31'd0, pw1}, 32'd0);
      obs_q1.push_back({end1, in1});
    end
    pw0 <= wr0;
    pw1 <= wr1;
  end

  // Reference model state.
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic        m_erro = 1'b0;
  logic        m_segura = 1'b0;
  logic        m_car = 1'b0;
  logic [15:0] m_pal = 16'h0000;

  logic [7:0] fr [0:31];
  int         fr_len;

  // Frame-level prediction: bytes before bad_idx are received cleanly.
  task automatic model_frame(input int bad_idx);
    int          lim;
    logic [15:0] n;
    logic [7:0]  soma;
    lim   = (bad_idx < 0) ? fr_len : bad_idx;
    n     = {fr[1], fr[2]};
    m_pal = 16'h0000;
    for (int i = 0; i < int'(n); i++) begin
      if (4 + 2 * i < lim) begin
        exp_q0.push_back({16'h0000 + 16'(i), fr[3 + 2 * i], fr[4 + 2 * i]});
        exp_q1.push_back({16'hFFFF + 16'(i), fr[3 + 2 * i], fr[4 + 2 * i]});
        m_pal = m_pal + 16'd1;
      end
    end
    m_car = 1'b0;
    if (bad_idx >= 0) begin
      m_erro   = 1'b1;
      m_segura = 1'b1;
    end else begin
      soma = 8'h00;
      for (int i = 1; i < fr_len - 1; i++) soma = soma ^ fr[i];
      m_erro   = (soma != fr[fr_len - 1]);
      m_segura = m_erro;
    end
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_nwr0"}, obs_q0.size(), exp_q0.size());
    chk({tag, "_nwr1"}, obs_q1.size(), exp_q1.size());
    for (int i = 0; i < obs_q0.size() && i < exp_q0.size(); i++)
      chk({tag, "_wr0"}, obs_q0[i], exp_q0[i]);
    for (int i = 0; i < obs_q1.size() && i < exp_q1.size(); i++)
      chk({tag, "_wr1"}, obs_q1[i], exp_q1[i]);
    chk({tag, "_erro"}, {31'd0, err0}, {31'd0, m_erro});
    chk({tag, "_segura"}, {31'd0, seg0}, {31'd0, m_segura});
    chk({tag, "_carregando"}, {31'd0, car0}, {31'd0, m_car});
    chk({tag, "_palavras"}, {16'd0, pal0}, {16'd0, m_pal});
    chk({tag, "_erro1"}, {31'd0, err1}, {31'd0, m_erro});
    chk({tag, "_segura1"}, {31'd0, seg1}, {31'd0, m_segura});
    chk({tag, "_palavras1"}, {16'd0, pal1}, {16'd0, m_pal});
    obs_q0.delete();
    obs_q1.delete();
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = bad ? 1'b0 : 1'b1;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
    if (bad) repeat (2 * CPB) @(negedge clock);
  endtask

  task automatic send_frame(input string tag, input int bad_idx);
    for (int i = 0; i < fr_len; i++) begin
      if (i == bad_idx) begin
        send_byte(fr[i], 1'b1);
        break;
      end
      send_byte(fr[i], 1'b0);
    end
    repeat (3 * CPB) @(negedge clock);
    model_frame(bad_idx);
    check_frame(tag);
  endtask

  task automatic set_frame(input int len, input logic [95:0] bytes);
    fr_len = len;
    for (int i = 0; i < len; i++) fr[i] = bytes[95 - 8 * i -: 8];
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_mem_wr"}, {31'd0, wr0}, 32'd0);
    chk({tag, "_mem_in"}, {16'd0, in0}, 32'd0);
    chk({tag, "_end0"}, {16'd0, end0}, 32'h0000);
    chk({tag, "_end1"}, {16'd0, end1}, 32'hFFFF);
    chk({tag, "_segura"}, {31'd0, seg0}, 32'd0);
    chk({tag, "_carregando"}, {31'd0, car0}, 32'd0);
    chk({tag, "_erro"}, {31'd0, err0}, 32'd0);
    chk({tag, "_palavras"}, {16'd0, pal0}, 32'd0);
  endtask

  // Directed scenarios followed by randomized frames.
  initial begin
    logic [7:0] s;
    int         n;
    int         bad;

    repeat (3) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    check_reset("reset");
    repeat (2 * CPB) @(negedge clock);

    set_frame(6, {8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h27, 48'd0});
    send_frame("single", -1);

    set_frame(10, {8'hA5, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'h00, 8'h01, 8'hFF, 8'hFE, 8'h12, 16'd0});
    send_frame("three", -1);

    set_frame(6, {8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h00, 48'd0});
    send_frame("badsum", -1);
    set_frame(6, {8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h27, 48'd0});
    send_frame("recover", -1);

    set_frame(6, {8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h27, 48'd0});
    send_frame("framing", 4);

    set_frame(8, {8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 32'd0});
    fr[7] = 8'h02 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF;
    send_frame("wrap", -1);

    set_frame(4, {8'hA5, 8'h00, 8'h00, 8'h00, 64'd0});
    send_frame("empty", -1);

    // One-cycle low pulse while idle, then one inside a frame.
    rx = 1'b0;
    @(negedge clock);
    rx = 1'b1;
    repeat (20 * CPB) @(negedge clock);
    check_frame("glitch_idle");
    set_frame(6, {8'hA5, 8'h00, 8'h01, 8'h56, 8'h78, 8'h00, 48'd0});
    fr[5] = 8'h01 ^ 8'h56 ^ 8'h78;
    for (int i = 0; i < 3; i++) send_byte(fr[i], 1'b0);
    rx = 1'b0;
    @(negedge clock);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    for (int i = 3; i < 6; i++) send_byte(fr[i], 1'b0);
    repeat (3 * CPB) @(negedge clock);
    model_frame(-1);
    check_frame("glitch_frame");

    // Reset in the middle of a data byte.
    set_frame(8, {8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 32'd0});
    fr[7] = 8'h02 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44;
    for (int i = 0; i < 3; i++) send_byte(fr[i], 1'b0);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clock);
    chk("mid_carregando", {31'd0, car0}, 32'd1);
    chk("mid_segura", {31'd0, seg0}, 32'd1);
    resetn = 1'b1;
    @(negedge clock);
    check_reset("mid_reset");
    rx = 1'b1;
    resetn = 1'b0;
    obs_q0.delete();
    obs_q1.delete();
    m_erro = 1'b0; m_segura = 1'b0; m_car = 1'b0; m_pal = 16'h0000;
    repeat (2 * CPB) @(negedge clock);
    send_frame("after_reset", -1);

    // Randomized frames: random length, data, checksum corruption, bad stop.
    for (int r = 0; r < 12; r++) begin
      n     = $urandom_range(0, 4);
      fr[0] = 8'hA5;
      fr[1] = 8'h00;
      fr[2] = 8'(n);
      s     = fr[2];
      for (int i = 0; i < 2 * n; i++) begin
        fr[3 + i] = 8'($urandom_range(0, 255));
        s = s ^ fr[3 + i];
      end
      if ($urandom_range(0, 3) == 0) s = s ^ 8'($urandom_range(1, 255));
      fr[3 + 2 * n] = s;
      fr_len = 4 + 2 * n;
      bad = ($urandom_range(0, 4) == 0) ? $urandom_range(1, fr_len - 1) : -1;
      send_frame("rand", bad);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
